// File: rtl/systolic_result_drain_if.sv
// Result stream from the drain to a narrow consumer: one element per beat with row/col tags.
interface systolic_result_drain_if #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 17
);
  localparam int unsigned RcW = (N > 1) ? $clog2(N) : 1;

  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [RcW-1:0] out_row;
  logic [RcW-1:0] out_col;
  logic           out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures an N*N result set from the systolic array and streams it out row-major,
// one element per beat, over a valid/ready handshake.
module systolic_result_drain #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    res_valid,
  input  logic [N*N*W-1:0]        c_flat,
  systolic_result_drain_if.master out_if,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    clr_overrun
);
  localparam int unsigned Elems = N * N;
  localparam int unsigned IdxW  = (Elems > 1) ? $clog2(Elems) : 1;
  localparam int unsigned RcW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    buf_q [Elems];
  logic [W-1:0]    buf_d [Elems];
  logic            overrun_q, overrun_d;

  logic            is_last;
  logic            xfer;
  logic [IdxW-1:0] idx_row, idx_col;

  assign is_last = (idx_q == IdxW'(Elems - 1));
  assign xfer    = (state_q == StDrain) && out_if.out_ready;
  assign idx_row = idx_q / IdxW'(N);
  assign idx_col = idx_q % IdxW'(N);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    overrun_d = overrun_q & ~clr_overrun;
    unique case (state_q)
      StIdle: begin
        if (res_valid) begin
          for (int k = 0; k < int'(Elems); k++) buf_d[k] = c_flat[k*W +: W];
          idx_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (xfer && is_last) begin
          idx_d = '0;
          // A set arriving on the last-beat transfer reloads with no bubble.
          if (res_valid) begin
            for (int k = 0; k < int'(Elems); k++) buf_d[k] = c_flat[k*W +: W];
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (xfer) idx_d = idx_q + IdxW'(1);
          if (res_valid) overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < int'(Elems); k++) buf_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      buf_q     <= buf_d;
    end
  end

  // Outputs are gated by state so they read zero whenever nothing is being offered.
  always_comb begin
    out_if.out_valid = 1'b0;
    out_if.out_data  = '0;
    out_if.out_row   = '0;
    out_if.out_col   = '0;
    out_if.out_last  = 1'b0;
    if (state_q == StDrain) begin
      out_if.out_valid = 1'b1;
      out_if.out_data  = buf_q[idx_q];
      out_if.out_row   = RcW'(idx_row);
      out_if.out_col   = RcW'(idx_col);
      out_if.out_last  = is_last;
    end
  end

  assign busy    = (state_q == StDrain);
  assign overrun = overrun_q;
endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Output-side reader for the systolic array. It captures the full N×N result set (c1..c9 for N=3) on the array's result-valid pulse and streams it out one element per beat, row-major, over a valid/ready handshake with row/column tags and a last flag. It sits between the array's c outputs and any narrow consumer such as a memory writer, UART or checker. It frees the array to start its next computation as soon as results are captured.

## Interface
Parameters:
- N, 3, array dimension; results per set = N*N
- W, 17, result width (8×8 product plus accumulation headroom)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- res_valid  in  1  one-cycle pulse: c_flat holds a complete result set
- c_flat  in  N*N*W  results, flattened; element k (c(k+1)) at bits [k*W +: W]; k = row*N + col
- out_valid  out  1  out_data/out_row/out_col/out_last are valid
- out_ready  in  1  consumer accepts the current beat
- out_data  out  W  current result element
- out_row  out  max(1,$clog2(N))  row index of out_data
- out_col  out  max(1,$clog2(N))  column index of out_data
- out_last  out  1  high on the final element (k = N*N-1) of a set
- busy  out  1  a set is held and not fully drained
- overrun  out  1  sticky: a res_valid pulse was dropped
- clr_overrun  in  1  synchronous clear of overrun

## Operation
- Storage: one N*N×W capture buffer plus an element index idx, width $clog2(N*N) (4 bits for N=3).
- FSM states: IDLE and DRAIN.
- IDLE:
  - res_valid=1: load the buffer from c_flat, set idx=0, go to DRAIN.
  - Otherwise hold.
- DRAIN:
  - out_valid=1.
  - out_data=buf[idx], out_row=idx/N, out_col=idx%N, out_last=(idx==N*N-1).
- Beat transfer occurs when out_valid && out_ready.
  - Non-last beat: idx+1.
  - Last beat with res_valid=1 in the same cycle: reload the buffer, idx=0, stay in DRAIN. No bubble, no overrun.
  - Last beat with res_valid=0: go to IDLE, idx=0.
- res_valid in DRAIN on any cycle other than a last-beat transfer: the new set is dropped. The buffer is untouched, overrun sets, and draining continues.
- overrun:
  - Cleared by clr_overrun.
  - Drop and clr_overrun in the same cycle: overrun = 1 (set wins).
- Stall: with out_valid=1 and out_ready=0, all out_* signals hold stable.
- busy = (state == DRAIN).
- out_valid never drops before its beat is accepted.
- Data is passed through unmodified: no truncation and no sign handling.

## Timing
- Reset values: out_valid 0, out_data 0, out_row 0, out_col 0, out_last 0, busy 0, overrun 0; idx 0; state IDLE; buffer 0.
- Reset mid-drain: the remaining elements are discarded and no beat is emitted after reset deasserts until a new res_valid arrives.
- Latency: res_valid sampled at edge T gives out_valid=1 with element 0 after T, visible in cycle T+1.
- Throughput: with out_ready held at 1, a set drains in exactly N*N cycles (9 for N=3). Back-to-back sets run at 100% with the reload on the last beat.
- All outputs are registered or derived only from registered state. There is no combinational path from out_ready or res_valid to any output.
- res_valid in IDLE is honoured in the same edge, regardless of out_ready.

## Test plan
- Basic drain: c_flat = 28,38,41,64,83,95,100,128,149 (k=0..8), res_valid pulse, out_ready=1.
  - Exactly 9 beats on consecutive cycles, starting one cycle after the pulse.
  - Tags (row,col) run (0,0)…(2,2); out_last only on 149; busy falls after beat 9.
- Backpressure: same set, out_ready toggles 1,0,0,1,…
  - No element skipped or duplicated; out_data/out_row/out_col stable while stalled.
  - Output order 28…149 unchanged.
- Overrun: second res_valid with c_flat all 17'h1FFFF at beat 4 of the first set.
  - First set is emitted intact and overrun=1 afterwards.
  - clr_overrun clears it; a simultaneous drop and clr leaves it at 1.
- Back-to-back: second set (all 17'h1FFFF) pulsed in the same cycle as the first set's last-beat transfer.
  - 18 contiguous beats; the second set is full width 131071.
  - overrun stays 0; busy stays 1 throughout.
- Reset mid-drain: assert reset asynchronously (off clock edge) after beat 3.
  - All outputs are 0 immediately; no further beats appear.
  - A new pulse afterwards drains from element 0.
- Idle hold: out_ready=1, no res_valid for 20 cycles.
  - out_valid stays 0, busy stays 0, out_data stays 0.
